// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction-memory owner. Boot phase writes bytes from the
//               loader. Run phase fetches one word per cycle with stall,
//               redirect and halt-on-zero-word handling.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_byte,
    input  logic        load_done,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic [15:0] boot_count
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic        if_valid_q,   if_valid_d;
    logic [31:0] if_pc_q,      if_pc_d;
    logic [31:0] if_instr_q,   if_instr_d;
    logic        halted_q,     halted_d;
    logic [15:0] boot_count_q, boot_count_d;

    logic [31:0] w_redirect_aligned;
    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= NOP_INSTR;
            halted_q     <= 1'b0;
            boot_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            halted_q     <= halted_d;
            boot_count_q <= boot_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        halted_d     = halted_q;
        boot_count_d = boot_count_q;
        case (state_q)
            S_BOOT: begin
                if (load_valid && (boot_count_q != 16'hFFFF)) begin
                    boot_count_d = boot_count_q + 16'd1;
                end
                if (load_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (redirect_valid) begin
                    pc_d       = w_redirect_aligned;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (mem_rdata == 32'h0000_0000) begin
                    // pc stays on the zero word so a debugger can see where fetch stopped
                    state_d    = S_HALT;
                    halted_d   = 1'b1;
                    if_valid_d = 1'b0;
                end else begin
                    if_instr_d = mem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            S_HALT: begin
                if_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d       = w_redirect_aligned;
                    halted_d   = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 8'h00;
        mem_addr   = pc_q;
        if (state_q == S_BOOT) begin
            load_ready = 1'b1;
            mem_we     = load_valid;
            mem_wdata  = load_byte;
            mem_addr   = load_addr;
        end
    end

    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_instr   = if_instr_q;
    assign halted     = halted_q;
    assign boot_count = boot_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Scoreboard bench for imem_fetch_ctrl with a byte memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid, load_ready, load_done;
    logic [31:0] load_addr;
    logic [7:0]  load_byte;
    logic [31:0] mem_addr, mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, halted;
    logic [31:0] if_pc, if_instr;
    logic [15:0] boot_count;

    imem_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_byte(load_byte), .load_done(load_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .halted(halted), .boot_count(boot_count)
    );

    always #5 clk = ~clk;

    // 64-byte memory model, address wraps modulo 64
    logic [7:0] mem [0:63];
    logic [5:0] ra;
    assign ra = mem_addr[5:0];
    assign mem_rdata = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};

    int we_count = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            we_count = we_count + 1;
        end
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // A held (stalled) instruction is not a new output
    logic stall_at_edge = 1'b0;
    always @(posedge clk) stall_at_edge <= stall;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if_valid && !stall_at_edge) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: got pc %h instr %h expected none", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_if_pc", if_pc, e.pc);
                chk("sb_if_instr", if_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] img [0:7];

    initial begin
        img[0] = 8'hB3; img[1] = 8'h81; img[2] = 8'h40; img[3] = 8'h00;
        img[4] = 8'hB3; img[5] = 8'h81; img[6] = 8'h11; img[7] = 8'h40;
        for (int i = 0; i < 64; i++) mem[i] = 8'h10 + 8'(i);
        for (int i = 20; i < 24; i++) mem[i] = 8'h00;

        rst = 1'b1; load_valid = 1'b0; load_done = 1'b0; load_addr = '0; load_byte = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        @(negedge clk);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_boot_count", {16'd0, boot_count}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        rst = 1'b0;

        // Boot: 8 bytes, load_done on the last one
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_addr  = 32'(i);
            load_byte  = img[i];
            load_done  = (i == 7);
            #1;
            chk("boot_we", {31'd0, mem_we}, 32'd1);
            chk("boot_addr", mem_addr, 32'(i));
            chk("boot_wdata", {24'd0, mem_wdata}, {24'd0, img[i]});
        end
        @(negedge clk);                                   // N0
        load_valid = 1'b0; load_done = 1'b0;
        chk("boot_load_ready_low", {31'd0, load_ready}, 32'd0);
        chk("boot_count", {16'd0, boot_count}, 32'd8);
        chk("boot_we_count", 32'(we_count), 32'd8);
        chk("run_mem_addr0", mem_addr, 32'h0);
        push_exp(32'h0, 32'h0040_81B3);
        push_exp(32'h4, 32'h4011_81B3);

        @(negedge clk);                                   // N1
        load_valid = 1'b1; load_addr = 32'h8; load_byte = 8'hFF;
        #1;
        chk("run_load_ignored_we", {31'd0, mem_we}, 32'd0);
        chk("run_load_ready", {31'd0, load_ready}, 32'd0);

        @(negedge clk);                                   // N2
        load_valid = 1'b0;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);                               // N3..N5
            chk("stall_if_pc", if_pc, 32'h4);
            chk("stall_if_instr", if_instr, 32'h4011_81B3);
            chk("stall_mem_addr", mem_addr, 32'h8);
            chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        push_exp(32'h8, 32'h1B1A_1918);

        @(negedge clk);                                   // N6
        redirect_valid = 1'b1; redirect_pc = 32'h13; stall = 1'b1;
        @(negedge clk);                                   // N7
        chk("redir_bubble", {31'd0, if_valid}, 32'd0);
        chk("redir_mem_addr", mem_addr, 32'h10);
        redirect_valid = 1'b0; stall = 1'b0;
        push_exp(32'h10, 32'h2322_2120);

        @(negedge clk);                                   // N8
        @(negedge clk);                                   // N9
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_if_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_mem_addr", mem_addr, 32'd20);
        stall = 1'b1;
        @(negedge clk);                                   // N10
        chk("halt_hold_addr", mem_addr, 32'd20);
        chk("halt_hold_halted", {31'd0, halted}, 32'd1);
        stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);                                   // N11
        chk("resume_bubble", {31'd0, if_valid}, 32'd0);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        redirect_valid = 1'b0;
        push_exp(32'h0, 32'h0040_81B3);

        @(negedge clk);                                   // N12
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);                                   // N13
        redirect_valid = 1'b0;
        chk("wrap_mem_addr", mem_addr, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC, 32'h4F4E_4D4C);
        @(negedge clk);                                   // N14
        chk("wrap_next_pc", mem_addr, 32'h0);
        push_exp(32'h0, 32'h0040_81B3);
        @(negedge clk);                                   // N15

        #3 rst = 1'b1;
        #1;
        chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_instr", if_instr, 32'h0000_0013);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("arst_boot_count", {16'd0, boot_count}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("boot_again_ready", {31'd0, load_ready}, 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequences the byte-addressed, little-endian instruction memory of the single-cycle core. After reset it runs a boot phase in which a program loader writes the memory one byte at a time. It then switches to run mode, where it drives the PC onto the memory, registers each fetched instruction with its PC for the decode stage, and handles stall, redirect (branch/jump) and halt-on-zero-word. It is the single owner of the memory address and write-enable lines.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; also the first fetch address after boot
NOP_INSTR, 32'h0000_0013, value of if_instr while no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
load_valid  in  1  loader offers one byte
load_ready  out  1  block accepts a loader byte this cycle
load_addr  in  32  byte address of the loader byte
load_byte  in  8  loader byte data
load_done  in  1  single-cycle pulse: end of program image
mem_addr  out  32  instruction-memory address
mem_we  out  1  instruction-memory byte write enable
mem_wdata  out  8  instruction-memory write byte
mem_rdata  in  32  combinational read {m[a+3],m[a+2],m[a+1],m[a]}
stall  in  1  decode not ready; hold PC and outputs
redirect_valid  in  1  branch/jump taken
redirect_pc  in  32  target PC
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_pc  out  32  PC of if_instr
if_instr  out  32  fetched instruction
halted  out  1  fetch stopped on zero word
boot_count  out  16  bytes accepted during boot

Behaviour:
- State machine: BOOT -> RUN -> HALT. Reset (async) forces BOOT, pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR, halted=0, boot_count=0.
- BOOT: load_ready=1. mem_addr=load_addr, mem_wdata=load_byte, and mem_we=load_valid, all combinational in the same cycle. Each accepted byte increments boot_count; the counter saturates at 16'hFFFF. stall and redirect are ignored. On load_done: next state is RUN. A byte offered in the load_done cycle is still written.
- RUN: load_ready=0, mem_we=0, mem_wdata=0, mem_addr=pc. Priority per cycle is redirect > stall > halt check > normal fetch.
  - redirect_valid: pc<={redirect_pc[31:2],2'b00}, if_valid<=0 (one bubble), if_instr<=NOP_INSTR.
  - stall only: pc, if_valid, if_pc and if_instr all hold.
  - mem_rdata==32'h0: state<=HALT, halted<=1, if_valid<=0, pc holds (points at the zero word).
  - otherwise: if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4.
- Fetch latency is 1 cycle: the instruction at address A appears on if_instr the cycle after pc==A. Throughput is one instruction per cycle with no stalls.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 gives 0. pc[1:0] is always 0.
- HALT: if_valid=0, halted=1, mem_addr=pc. redirect_valid resumes fetch: pc<=aligned target, halted<=0, state<=RUN, with a bubble that cycle. stall is ignored.
- load_valid/load_done outside BOOT are ignored: no write, and load_ready stays 0.
- Reset asserted mid-fetch or mid-boot aborts immediately and returns to BOOT. Memory contents are not cleared.

Test Plan:
- Boot: load bytes B3 81 40 00 B3 81 11 40 to addrs 0..7, then load_done -> mem_we high on exactly 8 cycles, boot_count=8, load_ready low from the cycle after load_done.
- Run: after boot with mem model -> if_instr=32'h004081B3 if_pc=0, next cycle 32'h401181B3 if_pc=4, if_valid=1 on both cycles.
- Stall: assert stall 3 cycles while if_pc=4 -> if_pc/if_instr/mem_addr unchanged for 3 cycles, then fetch continues at 8.
- Redirect: redirect_valid with redirect_pc=32'h13 in the same cycle as stall -> one bubble (if_valid=0), then if_pc=32'h10.
- Halt: word 0 at addr 20 -> halted=1, if_valid=0, mem_addr stays 20. Then redirect_pc=0 -> RUN, if_instr=32'h004081B3 one cycle after the bubble.
- Async reset mid-RUN (not clock-aligned) -> outputs immediately take reset values, load_ready=1. Wrap: redirect to 32'hFFFF_FFFC -> next pc=0.
